// File: rtl/day_11_pkg.sv
// day_11 shared constants and helpers.
// Counter sizing for the parallel-to-serial converter.
package day_11_pkg;

  localparam int DAY_11_WIDTH_DEFAULT = 4;

  // Bits needed to hold a count of 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/day_11.sv
// day_11: parallel-to-serial converter, LSB first.
// Reloads on the last bit so consecutive words stream gap-free.
module day_11
  import day_11_pkg::*;
#(
  parameter int WIDTH = DAY_11_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_i,
  output logic             serial_o,
  output logic             valid_o,
  output logic             empty_o
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             w_empty;
  logic             w_valid;

  // Status decode: empty on the last bit so a new word lands seamlessly.
  always_comb begin
    w_empty = (r_cnt == '0) || (r_cnt == CW'(1));
    w_valid = (r_cnt != '0);
  end

  // Load a fresh word when empty, otherwise shift out one bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_empty) begin
      r_shreg <= parallel_i;
      r_cnt   <= CW'(WIDTH);
    end else begin
      r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  // Serial data is masked to 0 whenever no word is in flight.
  always_comb begin
    serial_o = w_valid & r_shreg[0];
    valid_o  = w_valid;
    empty_o  = w_empty;
  end

endmodule

// File: tb/tb_day_11.sv
// tb_day_11: directed and randomized checks of day_11.
// Runs a WIDTH=4 and a WIDTH=8 instance from one sequence.
module tb_day_11;

  logic       clk;
  logic       reset;
  logic [3:0] p4;
  logic [7:0] p8;
  logic       s4, v4, e4;
  logic       s8, v8, e8;

  int checks;
  int fails;

  day_11 #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .parallel_i (p4),
    .serial_o   (s4),
    .valid_o    (v4),
    .empty_o    (e4)
  );

  day_11 #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .parallel_i (p8),
    .serial_o   (s8),
    .valid_o    (v8),
    .empty_o    (e8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present w to the 4-bit DUT, scramble the input mid-word,
  // and rebuild the word from the serial stream.
  task automatic send4(input logic [3:0] w, input string tag);
    logic [3:0] r;
    r = '0;
    chk({tag, "_empty_pre"}, 32'(e4), 32'd1);
    p4 = w;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk({tag, "_valid"}, 32'(v4), 32'd1);
      r[k] = s4;
      if (k < 3) begin
        chk({tag, "_busy"}, 32'(e4), 32'd0);
        p4 = 4'($urandom);
      end
    end
    chk({tag, "_word"}, 32'(r), 32'(w));
  endtask

  task automatic send8(input logic [7:0] w, input string tag);
    logic [7:0] r;
    r = '0;
    chk({tag, "_empty_pre"}, 32'(e8), 32'd1);
    p8 = w;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk({tag, "_valid"}, 32'(v8), 32'd1);
      r[k] = s8;
      if (k < 7) p8 = 8'($urandom);
    end
    chk({tag, "_word"}, 32'(r), 32'(w));
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b0;
    p4     = 4'h9;
    p8     = 8'h00;

    // Held in reset across two edges.
    #3;
    for (int c = 0; c < 3; c++) begin
      chk("rst_serial", 32'(s4), 32'd0);
      chk("rst_valid", 32'(v4), 32'd0);
      chk("rst_empty", 32'(e4), 32'd1);
      if (c < 2) tick();
    end
    chk("rst_valid8", 32'(v8), 32'd0);

    reset = 1'b1;
    #1;
    chk("idle_valid", 32'(v4), 32'd0);
    chk("idle_serial", 32'(s4), 32'd0);

    // Single word 1011 -> bits 1,1,0,1, then a zero word.
    p4 = 4'b1011;
    tick();
    chk("w1011_b0", 32'(s4), 32'd1);
    p4 = 4'h0;
    tick();
    chk("w1011_b1", 32'(s4), 32'd1);
    tick();
    chk("w1011_b2", 32'(s4), 32'd0);
    tick();
    chk("w1011_b3", 32'(s4), 32'd1);
    chk("w1011_b3_empty", 32'(e4), 32'd1);
    chk("w1011_b3_valid", 32'(v4), 32'd1);
    send4(4'h0, "zero");

    // Back-to-back A then 5: stream 0,1,0,1,1,0,1,0.
    send4(4'hA, "b2b_A");
    send4(4'h5, "b2b_5");

    // Reset in mid-word after two bits of F.
    p4 = 4'hF;
    tick();
    chk("midrst_b0", 32'(s4), 32'd1);
    p4 = 4'h3;
    tick();
    chk("midrst_b1", 32'(s4), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(v4), 32'd0);
    chk("midrst_serial", 32'(s4), 32'd0);
    chk("midrst_empty", 32'(e4), 32'd1);
    tick();
    #2;
    reset = 1'b1;
    send4(4'h6, "after_rst");

    // Random stream, 4-bit.
    for (int i = 0; i < 32; i++)
      send4(4'($urandom), "rnd4");

    // Random stream, 8-bit, from a clean reset.
    #2;
    reset = 1'b0;
    #1;
    chk("rst8_valid", 32'(v8), 32'd0);
    chk("rst8_serial", 32'(s8), 32'd0);
    tick();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 32; i++)
      send8(8'($urandom), "rnd8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
